// File: rtl/vec_mem_pkg.sv
// Shared types and helpers for the strided vector memory master.
// Holds SEW encodings, the FSM state type and lane mask/strobe helpers.
package vec_mem_pkg;

    localparam logic [1:0] SEW8   = 2'd0;
    localparam logic [1:0] SEW16  = 2'd1;
    localparam logic [1:0] SEW32  = 2'd2;
    localparam logic [1:0] SEWBAD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WB
    } state_t;

    function automatic logic [31:0] sew_mask(input logic [1:0] sew);
        logic [31:0] m;
        case (sew)
            SEW8:    m = 32'h0000_00ff;
            SEW16:   m = 32'h0000_ffff;
            SEW32:   m = 32'hffff_ffff;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] sew_strb(input logic [1:0] sew);
        logic [3:0] s;
        case (sew)
            SEW8:    s = 4'b0001;
            SEW16:   s = 4'b0011;
            SEW32:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/vec_lane_align.sv
// Byte-lane alignment between an element and a 32-bit memory word.
// Extracts load elements and shifts store data/strobes into place.
module vec_lane_align
    import vec_mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  sew,
    input  logic [31:0] rdata,
    input  logic [31:0] elem,
    output logic [31:0] elem_out,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [4:0] sh;

    assign sh       = {off, 3'b000};
    assign elem_out = (rdata >> sh) & sew_mask(sew);
    assign wdata    = elem << sh;
    assign wstrb    = sew_strb(sew) << off;

endmodule

// File: rtl/vec_strided_mem_master.sv
// Strided vector load/store initiator: one word transaction per element.
// Walks base + i*stride, aborting on illegal SEW or misaligned elements.
module vec_strided_mem_master
    import vec_mem_pkg::*;
#(
    parameter  int MAX_VL = 32,
    localparam int IW     = $clog2(MAX_VL + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_store,
    input  logic [31:0]   cmd_base,
    input  logic [31:0]   cmd_stride,
    input  logic [IW-1:0] cmd_vl,
    input  logic [1:0]    cmd_sew,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata,
    output logic          elem_we,
    output logic [IW-1:0] elem_idx,
    output logic [31:0]   elem_wdata,
    input  logic [31:0]   elem_rdata,
    output logic          done,
    output logic          err
);

    state_t        state;
    state_t        nxt;
    logic          store_q;
    logic [1:0]    sew_q;
    logic [31:0]   addr;
    logic [31:0]   stride;
    logic [IW-1:0] vl;
    logic [IW-1:0] idx;
    logic [31:0]   rdata_q;
    logic          fin;
    logic          bad;
    logic [31:0]   al_elem;
    logic [31:0]   al_wdata;
    logic [3:0]    al_wstrb;

    assign fin = (idx == vl);
    assign bad = (sew_q == SEWBAD)
               || ((sew_q == SEW16) && addr[0])
               || ((sew_q == SEW32) && (addr[1:0] != 2'b00));

    vec_lane_align u_align (
        .off      (addr[1:0]),
        .sew      (sew_q),
        .rdata    (rdata_q),
        .elem     (elem_rdata),
        .elem_out (al_elem),
        .wdata    (al_wdata),
        .wstrb    (al_wstrb)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (cmd_valid) nxt = S_CHECK;
            S_CHECK: nxt = (fin || bad) ? S_IDLE : S_REQ;
            S_REQ:   if (mem_ready) nxt = S_WB;
            S_WB:    nxt = S_CHECK;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        elem_we   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_CHECK: begin
                done = fin || bad;
                err  = !fin && bad;
            end
            S_REQ: begin
                mem_valid = 1'b1;
                mem_addr  = {addr[31:2], 2'b00};
                if (store_q) begin
                    mem_wdata = al_wdata;
                    mem_wstrb = al_wstrb;
                end
            end
            S_WB: elem_we = !store_q;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign elem_idx   = idx;
    assign elem_wdata = al_elem;

    // Command latch, element walk and load-data capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            store_q <= 1'b0;
            sew_q   <= SEW8;
            addr    <= 32'h0;
            stride  <= 32'h0;
            vl      <= '0;
            idx     <= '0;
            rdata_q <= 32'h0;
        end else begin
            if ((state == S_IDLE) && cmd_valid) begin
                store_q <= cmd_store;
                sew_q   <= cmd_sew;
                addr    <= cmd_base;
                stride  <= cmd_stride;
                vl      <= cmd_vl;
                idx     <= '0;
            end
            if ((state == S_REQ) && mem_ready) begin
                rdata_q <= mem_rdata;
            end
            if (state == S_WB) begin
                idx  <= idx + IW'(1);
                addr <= addr + stride;
            end
        end
    end

endmodule

// File: doc/vec_strided_mem_master.md
# vec_strided_mem_master

Initiator side of the vector coprocessor memory port. It executes one strided vector load or store per command. For each element it generates the element address (base + i·stride) and issues one word-wide valid/ready transaction per element. On loads it extracts the element from the returned word and writes it to the vector register file port; on stores it reads the element from the vector register file and drives lane-aligned data and strobes. It sits inside `picorv32_pcpi_vec` between the instruction decoder (command side) and the `mem_valid`/`mem_ready` memory interface.

## Interface
Parameters:
- `MAX_VL`, default 32: maximum element count; sets `cmd_vl` and `elem_idx` width `IW = $clog2(MAX_VL+1)`.

Ports:
- `clk`  in  1: clock. One clock domain.
- `resetn`  in  1: reset, asynchronous, active-low.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: high only in IDLE; the command is accepted when `cmd_valid && cmd_ready`.
- `cmd_store`  in  1: 1 = store, 0 = load.
- `cmd_base`  in  32: byte address of element 0.
- `cmd_stride`  in  32: signed byte stride.
- `cmd_vl`  in  IW: element count.
- `cmd_sew`  in  2: element width; 0 = 8, 1 = 16, 2 = 32 bits, 3 = illegal.
- `mem_valid`  out  1: request; held until `mem_ready`.
- `mem_ready`  in  1: one-cycle response pulse.
- `mem_addr`  out  32: word-aligned address (element address with bits [1:0] = 0).
- `mem_wdata`  out  32: store data, lane-shifted.
- `mem_wstrb`  out  4: byte strobes; 0 on loads.
- `mem_rdata`  in  32: load data, valid in the `mem_ready` cycle.
- `elem_we`  out  1: load element write pulse.
- `elem_idx`  out  IW: element index for both write and read.
- `elem_wdata`  out  32: extracted element, zero-extended.
- `elem_rdata`  in  32: store element, combinational from the register file for `elem_idx`.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: qualifies `done`; set for misaligned access or illegal SEW.

## Operation
- States: IDLE, CHECK, REQ, WB.
- IDLE: on accept, latch the command, set `addr = cmd_base` and `idx = 0`, then go to CHECK.
- CHECK:
  - If `idx == vl`: pulse `done` with `err = 0` and go to IDLE.
  - Else if `sew == 3`, or the address is misaligned to SEW (16-bit: `addr[0] != 0`; 32-bit: `addr[1:0] != 0`): pulse `done` with `err = 1`, go to IDLE, and issue no memory access.
  - Else go to REQ.
- REQ: `mem_valid = 1`, `mem_addr = {addr[31:2], 2'b00}`.
  - Store: `mem_wdata = elem_rdata << (8*addr[1:0])`; `mem_wstrb = {0001, 0011, 1111}[sew] << addr[1:0]`.
  - Load: `mem_wstrb = 0`.
  - When `mem_ready` is sampled high: drop `mem_valid`, capture `mem_rdata`, go to WB.
- WB:
  - Load: `elem_we = 1`, `elem_wdata = (rdata >> 8*addr[1:0]) & mask(sew)`.
  - Both directions: `idx <= idx+1`, `addr <= addr + stride` (32-bit modular, wraps silently), go to CHECK.
- Elements written before an error are kept; the abort is not rolled back.
- Outputs do not depend combinationally on `cmd_*`.

## Timing
- Reset values: state IDLE, `cmd_ready` = 1, and `mem_valid`, `mem_wstrb`, `elem_we`, `done`, `err` = 0. `mem_addr`, `mem_wdata`, `elem_idx`, `elem_wdata` = 0.
- Asserting `resetn` low mid-transaction forces IDLE immediately: `mem_valid` drops without waiting for `mem_ready`, and a late `mem_ready` arriving in IDLE is ignored.
- Accept at edge t: CHECK in cycle t+1, `mem_valid` first high in cycle t+2.
- With the standard responder (ready one cycle after valid) each element takes 4 cycles: REQ, REQ+ready, WB, CHECK.
- `vl = 0`: `done` in the cycle after accept, with no traffic.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for the whole REQ interval.
- `mem_valid` is never high in the cycle after `mem_ready`.
- `cmd_ready` is low from the cycle after accept through the `done` cycle. A new command can be accepted in the cycle after `done`.

## Structure
- `vec_mem_pkg` holds:
  - SEW encoding constants (`SEW8`, `SEW16`, `SEW32`);
  - the state enum;
  - `sew_mask()` and `sew_strb()` functions.
- Sub-module `vec_lane_align` is combinational:
  - inputs: `addr[1:0]`, `sew`, `rdata`, `elem`;
  - outputs: extracted element, shifted `wdata`, `wstrb`.
- The FSM, address/index counters and capture register live in `vec_strided_mem_master`.

## Test plan
- **Unit-stride byte load:** word@400 = 0x04030201, word@404 = 0x08070605; load, base 400, stride 1, sew 0, vl 4 → `elem_we` ×4 with idx 0..3 and data 0x01, 0x02, 0x03, 0x04; all `mem_addr` = 400; `done` with `err` = 0.
- **Strided halfword load:** base 400, stride 6, sew 1, vl 3 → reads at 400, 404, 412; elements 0x0201, 0x0807, and bytes [1:0] of word@412.
- **Byte store:** base 402, stride 4, sew 0, vl 2, `elem_rdata` = 0xAB → transactions (400, wdata 0x00AB0000, wstrb 0100) and (404, wdata 0x00AB0000, wstrb 0100).
- **Misaligned abort:** sew 2, base 400, stride 2, vl 3 → element 0 transferred; element 1 (addr 402) gets `done` with `err` = 1 and no second `mem_valid`.
- **Corner cases:**
  - `vl = 0` → `done` in cycle t+1, no traffic.
  - `sew = 3` → `err` = 1.
  - base 0xFFFFFFFC, stride 4, sew 2 → second address 0x00000000.
- **Reset mid-operation:** pull `resetn` low while `mem_valid` = 1 → `mem_valid` is 0 in the same cycle; after release, `cmd_ready` = 1 and a fresh 4-byte load completes correctly.
